// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array controller.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FEED   = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  // Number of anti-diagonals in an n x n PE array.
  function automatic int diag_cnt(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Per-lane delay line: data plus a valid bit shifted DEPTH cycles, zero-filled
// whenever the valid bit that travels with the data is low.
module skew_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_pass
    // Lane 0 has no skew; keep clk/rst on the port list so all lanes match.
    logic unused_clk_rst;
    assign unused_clk_rst = clk | rst;
    assign out_data = in_vld ? in_data : '0;
  end else begin : g_shift
    logic [DEPTH-1:0]                 vld_q, vld_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;

    // Next value of the shift chain: new sample enters at stage 0.
    always_comb begin
      vld_d     = vld_q;
      data_d    = data_q;
      vld_d[0]  = in_vld;
      data_d[0] = in_data;
      for (int s = 1; s < DEPTH; s++) begin
        vld_d[s]  = vld_q[s-1];
        data_d[s] = data_q[s-1];
      end
    end

    // Shift register with synchronous clear.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= '0;
        data_q <= '0;
      end else begin
        vld_q  <= vld_d;
        data_q <= data_d;
      end
    end

    assign out_data = vld_q[DEPTH-1] ? data_q[DEPTH-1] : '0;
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Systolic array job controller: reads K operand columns, skews them onto the
// array edges, flags each anti-diagonal's last operand and hands off a result.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 4,
  parameter int DIAG_NUM   = diag_cnt(ARRAY_SIZE),
  parameter int K_WIDTH    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [K_WIDTH-1:0]                   k_len,
  output logic                                 busy,
  output logic                                 rd_en,
  output logic [K_WIDTH-1:0]                   rd_addr,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] ifm_rd,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] w_rd,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] ifm_feed,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] w_feed,
  output logic [DIAG_NUM-1:0]                  done,
  output logic                                 res_valid,
  input  logic                                 res_ready
);

  state_t              state_q, state_d;
  logic [K_WIDTH-1:0]  cnt_q, cnt_d;
  logic [K_WIDTH-1:0]  k_q, k_d;
  logic                vld_q, vld_d;
  logic [DIAG_NUM-1:0] done_q, done_d;
  logic                last_rd;

  // Job FSM: next state, k counter and strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    rd_en     = 1'b0;
    busy      = 1'b1;
    res_valid = 1'b0;
    last_rd   = 1'b0;
    case (state_q)
      IDLE: begin
        busy  = 1'b0;
        cnt_d = '0;
        if (start && (k_len != '0)) begin
          k_d     = k_len;
          state_d = FEED;
        end
      end
      FEED: begin
        rd_en   = 1'b1;
        last_rd = (cnt_q == k_q - 1'b1);
        if (last_rd) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // The last diagonal's flag is out; one more cycle lets the PEs register it.
      DRAIN: if (done_q[DIAG_NUM-1]) state_d = RESULT;
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer data lands one cycle after rd_en; done walks one diagonal per cycle.
  always_comb begin
    vld_d     = rd_en;
    done_d    = '0;
    done_d[0] = last_rd;
    for (int d = 1; d < DIAG_NUM; d++) done_d[d] = done_q[d-1];
  end

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      vld_q   <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign rd_addr = cnt_q;
  assign done    = done_q;

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    skew_line #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_ifm (
      .clk(clk), .rst(rst), .in_vld(vld_q), .in_data(ifm_rd[i]), .out_data(ifm_feed[i])
    );
    skew_line #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_w (
      .clk(clk), .rst(rst), .in_vld(vld_q), .in_data(w_rd[i]), .out_data(w_feed[i])
    );
  end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: operand width.
REQ-002 The block SHALL have parameter ARRAY_SIZE, default 4: PE array rows and columns.
REQ-003 The block SHALL have parameter DIAG_NUM, default 2*ARRAY_SIZE-1: anti-diagonal count.
REQ-004 The block SHALL have parameter K_WIDTH, default 8: inner-dimension length width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: one-cycle job request.
REQ-008 The block SHALL have port k_len, input, K_WIDTH bits: inner dimension K, sampled on an accepted start.
REQ-009 The block SHALL have port busy, output, 1 bit: high from an accepted start until the result handshake completes.
REQ-010 The block SHALL have ports rd_en (output, 1 bit) and rd_addr (output, K_WIDTH bits): operand buffer read strobe and index k.
REQ-011 The block SHALL have ports ifm_rd and w_rd, each input, ARRAY_SIZE x DATA_WIDTH: buffer data, valid one cycle after rd_en.
REQ-012 The block SHALL have ports ifm_feed and w_feed, each output, ARRAY_SIZE x DATA_WIDTH: skewed operands to the array edges.
REQ-013 The block SHALL have port done, output, DIAG_NUM x 1: per-diagonal last-operand flags.
REQ-014 The block SHALL have ports res_valid (output, 1 bit) and res_ready (input, 1 bit): result handshake.

Function
REQ-015 The FSM SHALL use states IDLE, FEED, DRAIN and RESULT.
REQ-016 In IDLE, start=1 with k_len!=0 SHALL latch K and move to FEED; start with k_len=0 SHALL be ignored.
REQ-017 start SHALL be ignored whenever the FSM is not in IDLE.
REQ-018 In FEED, rd_en SHALL be 1 for exactly K consecutive cycles, with rd_addr counting 0..K-1; the FSM then SHALL move to DRAIN.
REQ-019 F SHALL denote the cycle after the first rd_en; ifm_feed[i] SHALL carry ifm_rd[i] for index k in cycle F+k+i, and 0 in every other cycle.
REQ-020 w_feed[j] SHALL carry w_rd[j] for index k in cycle F+k+j, and 0 in every other cycle.
REQ-021 done[d] SHALL be a one-cycle pulse in cycle F+K-1+d, for d = 0..DIAG_NUM-1, and 0 otherwise.
REQ-022 DRAIN SHALL end so that res_valid rises in cycle F+K+DIAG_NUM-1, one cycle after done[DIAG_NUM-1], allowing one PE register stage.
REQ-023 In RESULT, res_valid SHALL hold at 1 until a cycle with res_ready=1, then SHALL go to 0 with a return to IDLE in the next cycle.
REQ-024 The k counter SHALL count to K-1 without wrap; K=2^K_WIDTH-1 SHALL be supported.
REQ-025 busy SHALL be 1 in FEED, DRAIN and RESULT, and 0 in IDLE.

Reset
REQ-026 On rst=1, state SHALL be IDLE, and busy, rd_en, rd_addr, done, res_valid and all skew registers SHALL be 0.
REQ-027 A reset asserted mid-job SHALL abort the job; the feeds SHALL output only 0 from the next cycle on, and no done pulse SHALL follow.

Structure
REQ-028 A package systolic_pkg SHALL hold the state enum type and a diag_cnt(ARRAY_SIZE) constant function.
REQ-029 The per-lane delays SHALL use one sub-module, skew_line, with parameters DEPTH and DATA_WIDTH, a resettable shift register; lane i SHALL use DEPTH=i.
REQ-030 A per-lane valid bit SHALL travel with the data in skew_line and gate the zero-fill.

Verification (ARRAY_SIZE=4)
REQ-031 Scenario: start with K=1 and ifm_rd={1,2,3,4} -> ifm_feed[3]=4 only at F+3; done[0..6] pulse at F..F+6; res_valid at F+7.
REQ-032 Scenario: K=4 with identity weights and res_ready=1 -> rd_addr 0..3, busy for 4+7+1 cycles, no gaps in the feeds.
REQ-033 Scenario: res_ready held 0 for 5 cycles -> res_valid stays 1 and the feeds stay 0; the handshake completes on the first res_ready=1.
REQ-034 Scenario: start during FEED, and start with k_len=0 in IDLE -> both ignored; no rd_en and no state change.
REQ-035 Scenario: rst pulsed at F+2 of a K=4 job -> next cycle all outputs are 0, no done pulses follow, and a new start is accepted normally.
REQ-036 Scenario: back-to-back jobs with start on the cycle after return to IDLE -> the second job's timing is identical to the first, with no stale operands on the feeds.
